mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one byte-wide memory between a 16-bit instruction
// fetch port and a byte data port; round-robin on ties, all outputs registered.
module mem_port_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [15:0]       if_ins,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_valid,
    output logic [7:0]        d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, IF_LO, IF_HI, DATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic [15:0]       if_ins_q, if_ins_d;
    logic [7:0]        d_rdata_q, d_rdata_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic              last_was_data_q, last_was_data_d;
    logic              busy_q, busy_d;

    logic if_eligible, d_eligible, grant_data;

    // A requester still holding req in its own valid cycle has just been served.
    assign if_eligible = if_req & ~if_valid_q;
    assign d_eligible  = d_req & ~d_valid_q;
    assign grant_data  = d_eligible & (~if_eligible | ~last_was_data_q);

    always_comb begin
        state_d         = state_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = 1'b0;
        mem_wdata_d     = 8'h00;
        if_valid_d      = 1'b0;
        d_valid_d       = 1'b0;
        if_ins_d        = if_ins_q;
        d_rdata_d       = d_rdata_q;
        lo_byte_d       = lo_byte_q;
        last_was_data_d = last_was_data_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d         = DATA;
                    mem_addr_d      = d_addr;
                    mem_we_d        = d_we;
                    mem_wdata_d     = d_we ? d_wdata : 8'h00;
                    last_was_data_d = 1'b1;
                end else if (if_eligible) begin
                    state_d         = IF_LO;
                    mem_addr_d      = if_addr;
                    last_was_data_d = 1'b0;
                end
            end
            IF_LO: begin
                lo_byte_d  = mem_rdata;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                state_d    = IF_HI;
            end
            IF_HI: begin
                if_ins_d   = {mem_rdata, lo_byte_q};
                if_valid_d = 1'b1;
                state_d    = IDLE;
            end
            DATA: begin
                // mem_we_q doubles as the latched store/load flag for this cycle.
                d_rdata_d = mem_we_q ? 8'h00 : mem_rdata;
                d_valid_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= 8'h00;
            if_valid_q      <= 1'b0;
            d_valid_q       <= 1'b0;
            if_ins_q        <= 16'h0000;
            d_rdata_q       <= 8'h00;
            lo_byte_q       <= 8'h00;
            last_was_data_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            if_valid_q      <= if_valid_d;
            d_valid_q       <= d_valid_d;
            if_ins_q        <= if_ins_d;
            d_rdata_q       <= d_rdata_d;
            lo_byte_q       <= lo_byte_d;
            last_was_data_q <= last_was_data_d;
            busy_q          <= busy_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_ins    = if_ins_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// concurrent fetch/data traffic against a transaction-level memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [15:0]       if_ins;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [7:0]        d_wdata;
    logic              d_valid;
    logic [7:0]        d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_ins(if_ins),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared memory: combinational read, synchronous write.
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0;
        d_we = 1'b0; d_addr = '0; d_wdata = 8'h00;
        #1;
        checks++; if ({if_valid, d_valid, mem_we, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {if_valid, d_valid, mem_we, busy}); end
        checks++; if (if_ins !== 16'h0000) begin errors++; $display("[TB] FAIL reset_if_ins: got %h expected 0000", if_ins); end
        checks++; if (d_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_d_rdata: got %h expected 00", d_rdata); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_bus: got addr %h wdata %h expected 00 00", mem_addr, mem_wdata); end
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_fetch();
        do_reset();
        tb_mem[8'h10] = 8'h70; tb_mem[8'h11] = 8'h00;
        if_addr = 8'h10; if_req = 1'b1;
        tick();
        if_addr = 8'h55;
        checks++; if (mem_addr !== 8'h10 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fetch_lo: got addr %h busy %b expected 10 1", mem_addr, busy); end
        tick();
        checks++; if (mem_addr !== 8'h11 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_hi: got addr %h valid %b expected 11 0", mem_addr, if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_ins !== 16'h0070) begin errors++; $display("[TB] FAIL fetch_result: got valid %b ins %h expected 1 0070", if_valid, if_ins); end
        if_req = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0 || mem_addr !== 8'h11 || busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_after: got valid %b addr %h busy %b expected 0 11 0", if_valid, mem_addr, busy); end
    endtask

    task automatic test_wrap();
        tb_mem[8'hFF] = 8'h34; tb_mem[8'h00] = 8'h12;
        if_addr = 8'hFF; if_req = 1'b1;
        tick(2);
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 00", mem_addr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_ins !== 16'h1234) begin errors++; $display("[TB] FAIL wrap_ins: got valid %b ins %h expected 1 1234", if_valid, if_ins); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        d_we = 1'b1; d_addr = 8'h1F; d_wdata = 8'h07; d_req = 1'b1;
        tick();
        d_addr = 8'h00; d_wdata = 8'hEE;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h1F || mem_wdata !== 8'h07) begin errors++; $display("[TB] FAIL store_cycle: got we %b addr %h wdata %h expected 1 1f 07", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (d_valid !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 8'h00 || d_rdata !== 8'h00) begin errors++; $display("[TB] FAIL store_done: got valid %b we %b wdata %h rdata %h expected 1 0 00 00", d_valid, mem_we, mem_wdata, d_rdata); end
        checks++; if (tb_mem[8'h1F] !== 8'h07 || tb_mem[8'h00] !== 8'h12) begin errors++; $display("[TB] FAIL store_mem: got [1f]=%h [00]=%h expected 07 12", tb_mem[8'h1F], tb_mem[8'h00]); end
        checks++; if (if_ins !== 16'h1234) begin errors++; $display("[TB] FAIL if_ins_hold: got %h expected 1234", if_ins); end
        d_req = 1'b0;
        tick();
        d_we = 1'b0; d_addr = 8'h1F; d_req = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h1F) begin errors++; $display("[TB] FAIL load_cycle: got we %b addr %h expected 0 1f", mem_we, mem_addr); end
        tick();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 8'h07) begin errors++; $display("[TB] FAIL load_done: got valid %b rdata %h expected 1 07", d_valid, d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int t;
        bit exp_if [int];
        bit exp_d  [int];
        do_reset();
        tb_mem[8'h20] = 8'hA1; tb_mem[8'h21] = 8'hB2; tb_mem[8'h30] = 8'h5A;
        // Held requests alternate data (2 cycles) and fetch (3 cycles), data first.
        t = 0;
        for (int k = 0; k < 4; k++) begin
            t += 2; exp_d[t] = 1'b1;
            t += 3; exp_if[t] = 1'b1;
        end
        if_addr = 8'h20; d_addr = 8'h30; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++; if (if_valid !== exp_if.exists(c)) begin errors++; $display("[TB] FAIL rr_if_valid@%0d: got %b expected %b", c, if_valid, exp_if.exists(c)); end
            checks++; if (d_valid !== exp_d.exists(c)) begin errors++; $display("[TB] FAIL rr_d_valid@%0d: got %b expected %b", c, d_valid, exp_d.exists(c)); end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(2);
        if_req = 1'b1;
        tick();
        d_req = 1'b1;
        tick();
        checks++; if (d_valid !== 1'b0 || mem_addr !== 8'h21) begin errors++; $display("[TB] FAIL late_d_wait: got valid %b addr %h expected 0 21", d_valid, mem_addr); end
        tick();
        checks++; if (if_valid !== 1'b1 || d_valid !== 1'b0 || if_ins !== 16'hB2A1) begin errors++; $display("[TB] FAIL late_fetch_done: got %b %b %h expected 1 0 b2a1", if_valid, d_valid, if_ins); end
        if_req = 1'b0;
        tick();
        checks++; if (mem_addr !== 8'h30 || d_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_d_grant: got addr %h valid %b expected 30 0", mem_addr, d_valid); end
        tick();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 8'h5A) begin errors++; $display("[TB] FAIL late_d_done: got valid %b rdata %h expected 1 5a", d_valid, d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        tb_mem[8'h40] = 8'hAA;
        d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h55; d_req = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL mid_store_we: got %b expected 1", mem_we); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if ({mem_we, busy, d_valid, if_valid} !== 4'b0000 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || if_ins !== 16'h0000 || d_rdata !== 8'h00) begin errors++; $display("[TB] FAIL mid_store_reset: got we %b busy %b dv %b iv %b addr %h wd %h ins %h rd %h expected all zero", mem_we, busy, d_valid, if_valid, mem_addr, mem_wdata, if_ins, d_rdata); end
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (d_valid !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_quiet@%0d: got dv %b we %b expected 0 0", c, d_valid, mem_we); end
        end
        checks++; if (tb_mem[8'h40] !== 8'hAA) begin errors++; $display("[TB] FAIL mid_store_mem: got %h expected aa", tb_mem[8'h40]); end
        // After reset the round-robin must again favour data on a tie.
        if_addr = 8'h20; d_we = 1'b0; d_addr = 8'h30;
        if_req = 1'b1; d_req = 1'b1;
        tick();
        checks++; if (mem_addr !== 8'h30) begin errors++; $display("[TB] FAIL reset_rr_tie: got addr %h expected 30", mem_addr); end
        if_req = 1'b0; d_req = 1'b0;
        tick(5);
    endtask

    task automatic fetch_agent(input int n);
        logic [7:0] a;
        int waited;
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3));
            a = 8'($urandom);
            if_addr = a; if_req = 1'b1;
            waited = 0;
            do begin tick(); waited++; end while (if_valid !== 1'b1 && waited < 20);
            checks++;
            if (waited >= 20 && if_valid !== 1'b1) begin errors++; $display("[TB] FAIL rand_fetch_timeout: got no if_valid expected within 20 cycles"); end
            else if (if_ins !== {ref_mem[a + 8'd1], ref_mem[a]} || waited > 6) begin errors++; $display("[TB] FAIL rand_fetch@%h: got %h after %0d expected %h within 6", a, if_ins, waited, {ref_mem[a + 8'd1], ref_mem[a]}); end
            if_req = 1'b0;
        end
    endtask

    task automatic data_agent(input int n);
        logic [7:0] a, wd;
        logic       we;
        int waited;
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3));
            a = 8'($urandom); wd = 8'($urandom); we = 1'($urandom);
            d_addr = a; d_wdata = wd; d_we = we; d_req = 1'b1;
            waited = 0;
            do begin tick(); waited++; end while (d_valid !== 1'b1 && waited < 20);
            checks++;
            if (waited >= 20 && d_valid !== 1'b1) begin errors++; $display("[TB] FAIL rand_data_timeout: got no d_valid expected within 20 cycles"); end
            else if (we) begin
                if (d_rdata !== 8'h00 || waited > 6) begin errors++; $display("[TB] FAIL rand_store@%h: got rdata %h after %0d expected 00 within 6", a, d_rdata, waited); end
                ref_mem[a] = wd;
            end else if (d_rdata !== ref_mem[a] || waited > 6) begin
                errors++; $display("[TB] FAIL rand_load@%h: got %h after %0d expected %h within 6", a, d_rdata, waited, ref_mem[a]);
            end
            d_req = 1'b0;
        end
    endtask

    task automatic test_random_traffic();
        bit done;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        done = 1'b0;
        fork
            begin
                fork
                    fetch_agent(30);
                    data_agent(30);
                join
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !done; c++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (if_valid === 1'b1 && d_valid === 1'b1) begin errors++; $display("[TB] FAIL both_valid: got 1 1 expected at most one"); end
                end
            end
        join
        checks++;
        for (int i = 0; i < 256; i++) begin
            if (tb_mem[i] !== ref_mem[i]) begin errors++; $display("[TB] FAIL final_mem@%0d: got %h expected %h", i, tb_mem[i], ref_mem[i]); break; end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_wrap();
        test_store_load();
        test_contention();
        test_reset_mid_store();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
